neural_simd_pipe: RTL
=====================

Name: neural_simd_pipe

Overview:
- Parametrised, pipelined successor of the 4-lane neural SIMD datapath.
- Splits packed operand words into LANES lanes of PIX_W bits. Each lane is one neuron.
- Two modes per beat: masked temporal difference (stateless) or leaky integrate-and-fire (stateful membrane per lane).
- Sits between the custom-instruction operand fetch and writeback. Uses a valid/ready handshake in both directions so the core can stall it.

Parameters:
- LANES, 4, number of parallel neuron lanes (>=1).
- PIX_W, 8, bits per lane pixel/result.
- MEM_W, PIX_W+2, membrane potential width per lane (>=PIX_W+1).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat.
- in_mode  in  1  0=DIFF, 1=LIF; travels with the beat.
- rs1  in  LANES*PIX_W  pixel_t, lane i = bits [i*PIX_W +: PIX_W].
- rs2  in  LANES*PIX_W  pixel_t+1, same packing.
- mask  in  LANES*PIX_W  per-lane bit mask, same packing.
- thresh  in  MEM_W  firing threshold, shared by all lanes, quasi-static.
- leak  in  PIX_W  leak subtracted per LIF beat, quasi-static.
- clear  in  1  synchronous zeroing of all membranes.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result.
- rd  out  LANES*PIX_W  per-lane result.
- spike  out  LANES  per-lane fire flags for the current result beat.

Behaviour:
- Reset: in_ready=1, out_valid=0, rd=0, spike=0. The stage-1 valid bit and all membranes are set to 0.
- Advance enable: adv = !out_valid | out_ready.
  - in_ready = adv.
  - A beat is accepted when in_valid & in_ready.
- Stage 1 (when adv): s1_valid <= in_valid.
  - Per lane, register d = |rs2 - rs1| & mask. The absolute difference is unsigned, PIX_W bits, never wraps.
  - Register the mode with the beat.
- Stage 2 (when adv): out_valid <= s1_valid. rd and spike update only when s1_valid.
- Latency: 2 cycles from acceptance to out_valid with no stall. Throughput is 1 beat/cycle.
- Stall behaviour: while out_valid & !out_ready, rd, spike and stage 1 hold stable and in_ready=0.
- DIFF mode: rd lane = d, spike lane = 0, membrane unchanged.
- LIF mode, per lane, evaluated only on the stage-2 load (adv & s1_valid). Each beat updates the membrane exactly once.
  - Integrate: s = v + d, saturating at 2^MEM_W-1.
  - Leak: v' = s - leak, floored at 0 (unsigned, no underflow).
  - Fire when v' >= thresh: spike=1, rd lane = all ones, v <= 0.
  - No fire: spike=0, rd lane = min(v', 2^PIX_W-1), v <= v'.
- thresh=0: every LIF beat fires.
- clear: all membranes become 0 on the next edge.
  - If clear coincides with a LIF update, clear wins: the membrane ends at 0.
  - The beat's rd/spike are still produced from the pre-clear computation.
  - Pipeline valids are unaffected by clear.
- Reset mid-operation: in-flight beats are dropped. No out_valid is produced for them.

Optional Feature:
- Macro NEURAL_SIMD_SPIKE_CNT_EN.
- Defined: adds an output spike_cnt (32 bits) that accumulates popcount(spike) on every stage-2 LIF load.
  - Wraps modulo 2^32.
  - Reset to 0 by rst. Not affected by clear.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Package neural_simd_pkg holds:
  - Mode encoding constants MODE_DIFF=0 and MODE_LIF=1.
  - Default LANES/PIX_W values.
  - Helper functions for lane slicing and saturating add/sub.
- Sub-module neural_lif_lane: one lane's abs-diff/mask datapath, membrane register and fire logic. It is instantiated LANES times in a generate loop. Shared handshake and valid control stay in the top module.

Test Plan:
- Reset, then DIFF with rs1=0x10101010, rs2=0x30303030, mask=0xFFFFFFFF.
  - Expect rd=0x20202020 two cycles after acceptance, spike=0.
  - Then mask=0x0F0F0F0F gives rd=0x00000000.
- LIF, thresh=0x50, leak=0, d=0x20 per lane over 4 beats.
  - Expect rd lanes 0x20, 0x40, then 0xFF with spike=0xF, then 0x20.
- Back-pressure: out_ready low for 3 cycles during a LIF stream.
  - rd, spike and in_ready=0 hold stable throughout.
  - The membrane advances exactly once per beat, so the results match the no-stall sequence.
- Leak floor: leak=0x30 with d=0x10. Expect rd=0 and the membrane stays at 0 (no underflow).
  - Saturation: set thresh=2^MEM_W-1 and stream d=0xFF; rd saturates at 0xFF with spike=0 until threshold is hit.
- clear asserted on the same cycle as a LIF load.
  - The output beat is unchanged.
  - The next beat with d=0x20 yields rd=0x20.
- Assert rst with two beats in flight.
  - out_valid=0 immediately; no outputs are produced for the dropped beats.
  - After release, LIF starts from membrane 0.
  - With NEURAL_SIMD_SPIKE_CNT_EN, spike_cnt=0 after reset and equals the total spikes afterwards.

Source files
------------

// File: rtl/neural_simd_pkg.sv
// Shared definitions for the neural SIMD pipeline.
// Contents: mode encodings, default geometry, and helper functions used by
// the lane datapath: lane bit offset, absolute difference, saturating add
// and floored subtract. The arithmetic helpers work on 32-bit operands, so
// PIX_W and MEM_W must not exceed 32.
package neural_simd_pkg;

  localparam logic MODE_DIFF = 1'b0;
  localparam logic MODE_LIF  = 1'b1;

  localparam int DEF_LANES = 4;
  localparam int DEF_PIX_W = 8;

  // Bit offset of lane 'lane' in a word packed with 'width'-bit lanes.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

  // Unsigned |a - b|. This never wraps.
  function automatic logic [31:0] abs_diff(input logic [31:0] a,
                                           input logic [31:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // a + b, clamped to max_val.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_val);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, max_val}) ? max_val : s[31:0];
  endfunction

  // a - b, floored at zero.
  function automatic logic [31:0] sub_floor(input logic [31:0] a,
                                            input logic [31:0] b);
    return (a > b) ? (a - b) : 32'd0;
  endfunction

endpackage

// File: rtl/neural_simd_pipe_lane.sv
// One neuron lane: the stage-1 masked abs-diff register, the stage-2 result
// register and the lane's membrane potential.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   adv           pipeline advance; stage 1 captures d when high
//   load          stage-2 load (adv & s1_valid)
//   mode          mode of the beat held in stage 1 (MODE_DIFF / MODE_LIF)
//   clear         zero the membrane on the next edge (overrides the update)
//   rs1,rs2,mask  this lane's slices of the operand words
//   thresh, leak  shared firing threshold and per-beat leak
//   rd, spike     registered lane result and fire flag
//   fire          combinational: this lane fires on the current load
module neural_lif_lane
  import neural_simd_pkg::*;
#(
  parameter int PIX_W = DEF_PIX_W,
  parameter int MEM_W = PIX_W + 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             load,
  input  logic             mode,
  input  logic             clear,
  input  logic [PIX_W-1:0] rs1,
  input  logic [PIX_W-1:0] rs2,
  input  logic [PIX_W-1:0] mask,
  input  logic [MEM_W-1:0] thresh,
  input  logic [PIX_W-1:0] leak,
  output logic [PIX_W-1:0] rd,
  output logic             spike,
  output logic             fire
);

  localparam logic [31:0]      MEM_MAX = 32'((64'd1 << MEM_W) - 64'd1);
  localparam logic [PIX_W-1:0] PIX_MAX = '1;

  logic [PIX_W-1:0] d_q;
  logic [MEM_W-1:0] mem;
  logic [MEM_W-1:0] sum;
  logic [MEM_W-1:0] v_next;
  logic             fire_c;
  logic [PIX_W-1:0] rd_lif;

  // Stage 1: masked absolute temporal difference.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q <= '0;
    end else if (adv) begin
      d_q <= PIX_W'(abs_diff(32'(rs2), 32'(rs1))) & mask;
    end
  end

  // Integrate (saturating), leak (floored), then compare with the threshold.
  always_comb begin
    sum    = MEM_W'(sat_add(32'(mem), 32'(d_q), MEM_MAX));
    v_next = MEM_W'(sub_floor(32'(sum), 32'(leak)));
    fire_c = (v_next >= thresh);
    rd_lif = PIX_MAX;
    if (!fire_c) begin
      rd_lif = (v_next > {{(MEM_W - PIX_W){1'b0}}, PIX_MAX}) ? PIX_MAX
                                                             : PIX_W'(v_next);
    end
  end

  assign fire = load & (mode == MODE_LIF) & fire_c;

  // Stage 2: the result registers load only on a valid beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd    <= '0;
      spike <= 1'b0;
    end else if (load) begin
      if (mode == MODE_LIF) begin
        rd    <= rd_lif;
        spike <= fire_c;
      end else begin
        rd    <= d_q;
        spike <= 1'b0;
      end
    end
  end

  // Membrane: clear beats any same-cycle update. It changes only on a LIF
  // load, so a stalled beat never integrates twice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '0;
    end else if (clear) begin
      mem <= '0;
    end else if (load && mode == MODE_LIF) begin
      mem <= fire_c ? '0 : v_next;
    end
  end

endmodule

// File: rtl/neural_simd_pipe.sv
// Two-stage SIMD neuron pipeline: LANES lanes of masked temporal difference
// (DIFF) or leaky integrate-and-fire (LIF), selected per beat.
// Optional build macro: NEURAL_SIMD_SPIKE_CNT_EN adds a 32-bit spike_cnt
// output. It accumulates the number of lanes firing on each stage-2 LIF load,
// wraps modulo 2^32, is cleared by rst, and ignores clear.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   operand beat handshake (in_mode, rs1, rs2, mask)
//   thresh, leak        quasi-static LIF parameters
//   clear               zero all membranes on the next edge
//   out_valid/out_ready result beat handshake (rd, spike)
//   spike_cnt           total spikes (only with NEURAL_SIMD_SPIKE_CNT_EN)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid and data stable until that edge, and
// ready does not depend on valid. Here in_ready = adv = !out_valid | out_ready,
// so the whole pipeline freezes while a result waits for its consumer.
module neural_simd_pipe
  import neural_simd_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int PIX_W = DEF_PIX_W,
  parameter int MEM_W = PIX_W + 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_mode,
  input  logic [LANES*PIX_W-1:0] rs1,
  input  logic [LANES*PIX_W-1:0] rs2,
  input  logic [LANES*PIX_W-1:0] mask,
  input  logic [MEM_W-1:0]       thresh,
  input  logic [PIX_W-1:0]       leak,
  input  logic                   clear,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*PIX_W-1:0] rd,
  output logic [LANES-1:0]       spike
`ifdef NEURAL_SIMD_SPIKE_CNT_EN
  ,
  output logic [31:0]            spike_cnt
`endif
);

  logic             adv;
  logic             load;
  logic             s1_valid;
  logic             s1_mode;
  logic [LANES-1:0] fire;

  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;
  assign load     = adv & s1_valid;

  // A bubble in stage 1 also advances, which is what drops out_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_mode   <= MODE_DIFF;
      out_valid <= 1'b0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s1_mode   <= in_mode;
      out_valid <= s1_valid;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    neural_lif_lane #(
      .PIX_W (PIX_W),
      .MEM_W (MEM_W)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .adv    (adv),
      .load   (load),
      .mode   (s1_mode),
      .clear  (clear),
      .rs1    (rs1[lane_lsb(g, PIX_W) +: PIX_W]),
      .rs2    (rs2[lane_lsb(g, PIX_W) +: PIX_W]),
      .mask   (mask[lane_lsb(g, PIX_W) +: PIX_W]),
      .thresh (thresh),
      .leak   (leak),
      .rd     (rd[lane_lsb(g, PIX_W) +: PIX_W]),
      .spike  (spike[g]),
      .fire   (fire[g])
    );
  end

`ifdef NEURAL_SIMD_SPIKE_CNT_EN
  logic [31:0] fire_cnt;

  always_comb begin
    fire_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      fire_cnt = fire_cnt + 32'(fire[i]);
    end
  end

  // fire is already qualified with the LIF load, so DIFF beats add nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spike_cnt <= '0;
    end else begin
      spike_cnt <= spike_cnt + fire_cnt;
    end
  end
`else
  logic unused_fire;
  assign unused_fire = ^fire;
`endif

endmodule
